mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with the HI/LO result registers; sits directly downstream of the register file.
- Consumes the two register-file read ports (rs to OperandA, rt to OperandB) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Its Hi/Lo outputs feed the write-back mux that drives register-file write data for MFHI/MFLO.
- Multi-cycle with a Start/Busy/Done handshake; the control unit stalls the PC while Busy is high.

Parameters:
- WIDTH, 32, operand width in bits; Hi and Lo are WIDTH each.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- OperandA  input  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source).
- OperandB  input  WIDTH  rt value (multiplier / divisor).
- Busy  output  1  registered; high while an iterative operation is in flight.
- Done  output  1  registered; one-cycle pulse when Hi/Lo take a mul/div result.
- Hi  output  WIDTH  HI register (product high word / remainder).
- Lo  output  WIDTH  LO register (product low word / quotient).

Behaviour:
- Reset is synchronous, active-high and dominates every other input.
  - Outputs: Hi=0, Lo=0, Busy=0, Done=0.
  - State returns to IDLE and the counter clears; any in-flight operation is aborted with no partial result.
- States: IDLE, CALC, FINISH.
- IDLE with Start=1, Op=MTHI: Hi<=OperandA in one cycle; Lo unchanged, Busy stays 0, Done stays 0.
- IDLE with Start=1, Op=MTLO: Lo<=OperandA in one cycle; Hi unchanged, Busy stays 0, Done stays 0.
- IDLE with Start=1, Op=11x: no effect.
- IDLE with Start=1, Op=000..011:
  - Latch op and operands; for signed ops latch absolute values plus the sign bits.
  - counter<=0, Busy<=1, go to CALC.
- CALC runs one iteration per cycle.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring divide; shift remainder, trial-subtract the divisor, set the quotient bit.
  - When counter==WIDTH-1, go to FINISH; CALC lasts exactly WIDTH cycles.
- FINISH, one cycle:
  - Apply sign fix-up.
  - Write Hi/Lo, Done<=1, Busy<=0, go to IDLE.
- Timing, with Start accepted at edge N:
  - Busy=1 after edge N through edge N+WIDTH+1 (33 cycles at default).
  - Hi/Lo valid and Done=1 after edge N+WIDTH+1.
  - Done is cleared on the next edge.
- Start while Busy=1 (CALC or FINISH) is ignored, including MTHI/MTLO. It is not queued.
- Hi/Lo hold their old values during CALC; partial results are never visible.
- Sign rules:
  - Signed product is negated if signA^signB.
  - Signed quotient is negated if signA^signB.
  - Signed remainder takes the dividend's sign.
  - Unsigned ops perform no fix-up.
- Divide by zero (OperandB==0, any divide op):
  - Full latency still applies.
  - Lo=all ones, Hi=OperandA as latched (raw value, no fix-up).
- Signed overflow 0x80000000 / -1: Lo=0x80000000, Hi=0. No exception or flag.
- Operand inputs may change after the Start edge without effect.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD (-3), B=5 -> Busy high 33 cycles; Done pulse once; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001 after 33 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000064.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0. Then MTHI A=0x12345678 -> next cycle Hi=0x12345678, Lo unchanged, Busy/Done stay 0.
- Start MULTU 7*6; at cycle 5 pulse Start with Op=MTLO A=0xDEAD -> MTLO ignored; Hi=0, Lo=0x2A at Done.
- Start DIVU, assert Reset at cycle 10 -> next edge Busy=0, Hi=Lo=0, no Done pulse. A new MULT 2*3 then completes normally with Lo=6.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiply / restoring divide with HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_a, r_b, r_araw;
  logic                 r_div, r_uns, r_sa, r_sb, r_bz;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]     w_q, w_r;
  always_comb begin
    w_abs_a    = (!Op[0] && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    w_abs_b    = (!Op[0] && OperandB[WIDTH-1]) ? -OperandB : OperandB;
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
    // Remainder lives in the upper half, dividend/quotient bits shift through the lower half
    w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff     = w_rem_sh - {1'b0, r_b};
    w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                               : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    w_prod     = (!r_uns && (r_sa ^ r_sb)) ? -r_acc : r_acc;
    w_q        = (!r_uns && (r_sa ^ r_sb)) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_r        = (!r_uns && r_sa) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_araw  <= '0;
      r_div   <= 1'b0;
      r_uns   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_bz    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE: if (Start) begin
          if (Op == 3'b100) Hi <= OperandA;
          if (Op == 3'b101) Lo <= OperandA;
          if (!Op[2]) begin
            r_div   <= Op[1];
            r_uns   <= Op[0];
            r_sa    <= !Op[0] && OperandA[WIDTH-1];
            r_sb    <= !Op[0] && OperandB[WIDTH-1];
            r_bz    <= OperandB == '0;
            r_araw  <= OperandA;
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_acc   <= Op[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            r_cnt   <= '0;
            Busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc   <= r_div ? w_div_next : w_mul_next;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CNT_W'(WIDTH-1)) ? FINISH : CALC;
        end
        FINISH: begin
          Hi      <= !r_div ? w_prod[2*WIDTH-1:WIDTH] : r_bz ? r_araw : w_r;
          Lo      <= !r_div ? w_prod[WIDTH-1:0] : r_bz ? '1 : w_q;
          Done    <= 1'b1;
          Busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
